// File: rtl/alu_issue.sv
// Issue/writeback controller for a combinational ALU: accepts one instruction at a time,
// reads operands from a 16x32 register file, drives the ALU and writes the result back.
module alu_issue #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  input  logic [WIDTH-1:0] alu_res,
  output logic             wb_valid,
  output logic [3:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int unsigned AW  = 4;
  localparam int unsigned IMW = 16;

  typedef struct packed {
    logic [3:0]     opcode;
    logic [AW-1:0]  rd;
    logic [AW-1:0]  rs1;
    logic [AW-1:0]  rs2;
    logic [IMW-1:0] imm;
  } instr_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ready;
  logic             w_accept;
  instr_t           r_instr;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_rf [NREGS];
  logic [WIDTH-1:0] w_rs1_val;
  logic [WIDTH-1:0] w_rs2_val;
  logic [WIDTH-1:0] w_src_a;
  logic [WIDTH-1:0] w_src_b;

  assign instr_ready = r_ready;
  assign w_accept    = instr_valid && r_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: fixed four-cycle walk once an instruction is accepted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC:   w_state_nxt = S_WB;
      S_WB:     w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Operand decode; r0 reads as zero, immediates are zero-extended
  always_comb begin
    w_rs1_val = (r_instr.rs1 == '0) ? '0 : r_rf[r_instr.rs1];
    w_rs2_val = (r_instr.rs2 == '0) ? '0 : r_rf[r_instr.rs2];
    w_src_a   = w_rs1_val;
    w_src_b   = w_rs2_val;
    if (r_instr.opcode[3]) begin
      w_src_b = WIDTH'(r_instr.imm);
      if (r_instr.opcode[2:0] == 3'b000) w_src_a = WIDTH'(r_instr.imm);
    end
  end

  // Datapath registers: ready flag, instruction latch, ALU drive, result, writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready   <= 1'b0;
      r_instr   <= '0;
      alu_op    <= '0;
      alu_src_a <= '0;
      alu_src_b <= '0;
      r_result  <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      r_ready  <= (w_state_nxt == S_IDLE);
      wb_valid <= 1'b0;
      if (r_state == S_IDLE && w_accept) r_instr <= instr;
      if (r_state == S_DECODE) begin
        alu_op    <= r_instr.opcode[2:0];
        alu_src_a <= w_src_a;
        alu_src_b <= w_src_b;
      end
      if (r_state == S_EXEC) r_result <= alu_res;
      if (r_state == S_WB) begin
        wb_valid <= 1'b1;
        wb_addr  <= r_instr.rd;
        wb_data  <= r_result;
      end
    end
  end

  // Register file; writes to r0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) r_rf[i] <= '0;
    end else if (r_state == S_WB && r_instr.rd != '0) begin
      r_rf[r_instr.rd] <= r_result;
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue with a behavioural ALU closing the loop.
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [2:0]  alu_op;
  logic [31:0] alu_src_a;
  logic [31:0] alu_src_b;
  logic [31:0] alu_res;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks;
  int failures;

  alu_issue #(.NREGS(16), .WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_res(alu_res),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU
  always_comb begin
    case (alu_op)
      3'b000:  alu_res = alu_src_a;
      3'b001:  alu_res = alu_src_a + alu_src_b;
      3'b010:  alu_res = alu_src_a * alu_src_b;
      3'b100:  alu_res = alu_src_a ^ alu_src_b;
      3'b110:  alu_res = alu_src_a | alu_src_b;
      3'b111:  alu_res = alu_src_a & alu_src_b;
      default: alu_res = 32'h0;
    endcase
  end

  // Issue one instruction and wait for its writeback pulse (latency counted in edges)
  task automatic send(input logic [31:0] w, output int waited, output int lat,
                      output logic [3:0] a, output logic [31:0] d);
    waited = 0;
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 32'h0;
    lat = -1;
    a = 4'h0;
    d = 32'h0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (wb_valid) begin
        lat = k;
        a = wb_addr;
        d = wb_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 32'h0;
    dbg_addr = 4'h0;
    #12;
    checks++;
    if (instr_ready !== 1'b0 || wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b wb_valid=%b expected 0/0", instr_ready, wb_valid);
    end
    checks++;
    if (alu_op !== 3'h0 || alu_src_a !== 32'h0 || alu_src_b !== 32'h0 ||
        wb_addr !== 4'h0 || wb_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs: op=%h a=%h b=%h wa=%h wd=%h expected all 0",
               alu_op, alu_src_a, alu_src_b, wb_addr, wb_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b expected 1", instr_ready);
    end
  endtask

  task automatic test_movi();
    int w, l;
    logic [3:0] a;
    logic [31:0] d;
    send(32'h8100_0005, w, l, a, d);
    checks++;
    if (l !== 3 || a !== 4'd1 || d !== 32'h5) begin
      failures++;
      $display("FAIL movi_r1: lat=%0d addr=%h data=%h expected 3/1/00000005", l, a, d);
    end
    checks++;
    if (alu_op !== 3'b000 || alu_src_a !== 32'h5 || alu_src_b !== 32'h5) begin
      failures++;
      $display("FAIL movi_alu_hold: op=%h a=%h b=%h expected 0/5/5", alu_op, alu_src_a, alu_src_b);
    end
    dbg_addr = 4'd1; #1;
    checks++;
    if (dbg_data !== 32'h5) begin
      failures++;
      $display("FAIL movi_dbg_r1: got %h expected 00000005", dbg_data);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL wb_pulse_width: wb_valid=%b expected 0", wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    int w, l;
    logic [3:0] a;
    logic [31:0] d;
    send(32'h8200_0007, w, l, a, d);
    checks++;
    if (l !== 3 || a !== 4'd2 || d !== 32'h7) begin
      failures++;
      $display("FAIL movi_r2: lat=%0d addr=%h data=%h expected 3/2/00000007", l, a, d);
    end
    send(32'h1312_0000, w, l, a, d);
    checks++;
    if (w !== 0 || l !== 3 || a !== 4'd3 || d !== 32'hC) begin
      failures++;
      $display("FAIL add_dep: wait=%0d lat=%0d addr=%h data=%h expected 0/3/3/0000000c", w, l, a, d);
    end
    dbg_addr = 4'd3; #1;
    checks++;
    if (dbg_data !== 32'hC) begin
      failures++;
      $display("FAIL add_dbg_r3: got %h expected 0000000c", dbg_data);
    end
  endtask

  task automatic test_wrap_mul();
    logic [31:0] prog [5] = '{32'h8100_FFFF, 32'h8800_0100, 32'hA888_0100,
                              32'h2918_0000, 32'h6191_0000};
    logic [31:0] expd [5] = '{32'h0000_FFFF, 32'h0000_0100, 32'h0001_0000,
                              32'hFFFF_0000, 32'hFFFF_FFFF};
    int w, l;
    logic [3:0] a;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) begin
      send(prog[i], w, l, a, d);
      checks++;
      if (l !== 3 || d !== expd[i]) begin
        failures++;
        $display("FAIL chain_%0d: lat=%0d data=%h expected 3/%h", i, l, d, expd[i]);
      end
    end
    send(32'h9410_0002, w, l, a, d);
    checks++;
    if (a !== 4'd4 || d !== 32'h1) begin
      failures++;
      $display("FAIL addi_wrap: addr=%h data=%h expected 4/00000001", a, d);
    end
    send(32'h2588_0000, w, l, a, d);
    checks++;
    if (a !== 4'd5 || d !== 32'h0) begin
      failures++;
      $display("FAIL mul_low32: addr=%h data=%h expected 5/00000000", a, d);
    end
  endtask

  task automatic test_logic_ops();
    logic [31:0] prog [7] = '{32'h8A00_F0F0, 32'h8B00_0FF0, 32'h4CAB_0000, 32'h6CAB_0000,
                              32'h7CAB_0000, 32'h3CAB_0000, 32'hCCA0_0FF0};
    logic [31:0] expd [7] = '{32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 32'h0000_FFF0,
                              32'h0000_00F0, 32'h0000_0000, 32'h0000_FF00};
    int w, l;
    logic [3:0] a;
    logic [31:0] d;
    for (int i = 0; i < 7; i++) begin
      send(prog[i], w, l, a, d);
      checks++;
      if (l !== 3 || a !== prog[i][27:24] || d !== expd[i]) begin
        failures++;
        $display("FAIL logic_%0d: lat=%0d addr=%h data=%h expected 3/%h/%h",
                 i, l, a, d, prog[i][27:24], expd[i]);
      end
    end
  endtask

  task automatic test_r0();
    int w, l;
    logic [3:0] a;
    logic [31:0] d;
    send(32'h8000_0009, w, l, a, d);
    checks++;
    if (l !== 3 || a !== 4'd0 || d !== 32'h9) begin
      failures++;
      $display("FAIL r0_write_wb: lat=%0d addr=%h data=%h expected 3/0/00000009", l, a, d);
    end
    dbg_addr = 4'd0; #1;
    checks++;
    if (dbg_data !== 32'h0) begin
      failures++;
      $display("FAIL r0_dbg: got %h expected 00000000", dbg_data);
    end
    send(32'h8600_0003, w, l, a, d);
    send(32'h1600_0000, w, l, a, d);
    checks++;
    if (a !== 4'd6 || d !== 32'h0) begin
      failures++;
      $display("FAIL r0_operands: addr=%h data=%h expected 6/00000000", a, d);
    end
  endtask

  task automatic test_dbg_timing();
    @(posedge clk); #1;
    instr = 32'h8D00_0055;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (alu_src_a !== 32'h55 || alu_op !== 3'b000) begin
      failures++;
      $display("FAIL decode_edge: a=%h op=%h expected 00000055/0", alu_src_a, alu_op);
    end
    @(posedge clk); #1;
    dbg_addr = 4'd13; #1;
    checks++;
    if (dbg_data !== 32'h0 || wb_valid !== 1'b0 || instr_ready !== 1'b0) begin
      failures++;
      $display("FAIL wb_cycle_prewrite: dbg=%h wbv=%b rdy=%b expected 0/0/0",
               dbg_data, wb_valid, instr_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (dbg_data !== 32'h55 || wb_valid !== 1'b1 || instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL wb_cycle_post: dbg=%h wbv=%b rdy=%b expected 00000055/1/1",
               dbg_data, wb_valid, instr_ready);
    end
  endtask

  task automatic test_throughput();
    int acc [$];
    int wbs [$];
    @(posedge clk); #1;
    instr = 32'h8E00_0001;
    instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (instr_ready) acc.push_back(c);
      if (wb_valid) wbs.push_back(c);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (acc.size() != 3 || acc[0] != 0 || acc[1] != 4 || acc[2] != 8) begin
      failures++;
      $display("FAIL throughput_accepts: count=%0d expected 3 at cycles 0,4,8", acc.size());
    end
    checks++;
    if (wbs.size() != 2 || wbs[0] != 4 || wbs[1] != 8) begin
      failures++;
      $display("FAIL throughput_wb: count=%0d expected 2 at cycles 4,8", wbs.size());
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(posedge clk); #1;
    instr = 32'h8F00_0077;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b0 || wb_valid !== 1'b0 || alu_src_a !== 32'h0 || wb_data !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs: rdy=%b wbv=%b a=%h wd=%h expected 0/0/0/0",
               instr_ready, wb_valid, alu_src_a, wb_data);
    end
    bad = 0;
    for (int r = 0; r < 16; r++) begin
      dbg_addr = 4'(r); #1;
      if (dbg_data !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midreset_rf_clear: nonzero_regs=%0d expected 0", bad);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready: got %b expected 1", instr_ready);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (wb_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    dbg_addr = 4'd15; #1;
    checks++;
    if (bad != 0 || dbg_data !== 32'h0) begin
      failures++;
      $display("FAIL midreset_no_wb: wb_pulses=%0d r15=%h expected 0/00000000", bad, dbg_data);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_movi();
    test_back_to_back();
    test_wrap_mul();
    test_logic_ops();
    test_r0();
    test_dbg_timing();
    test_throughput();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
